// File: rtl/mips_multicycle_datapath_if.sv
// rtl/mips_multicycle_datapath_if.sv - control strobes and memory port of the multicycle MIPS datapath
interface mips_multicycle_datapath_if;
    logic        IorD;
    logic        MemWrite;
    logic        IRWrite;
    logic        PCWrite;
    logic        Branch;
    logic        PCSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic        RegWrite;
    logic        RegDst;
    logic        MemtoReg;
    logic [31:0] mem_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        zero;
    logic [31:0] dbg_pc;

    modport master (
        output IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegWrite, RegDst, MemtoReg, mem_rdata,
        input  mem_addr, mem_wdata, mem_we, Op, Funct, zero, dbg_pc
    );

    modport slave (
        input  IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB,
               ALUControl, RegWrite, RegDst, MemtoReg, mem_rdata,
        output mem_addr, mem_wdata, mem_we, Op, Funct, zero, dbg_pc
    );
endinterface

// File: rtl/mips_multicycle_datapath.sv
// rtl/mips_multicycle_datapath.sv - multicycle MIPS datapath driven purely by control strobes
module mips_multicycle_datapath #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input logic                   clk,
    input logic                   reset,
    mips_multicycle_datapath_if.slave bus
);

    logic [DATA_W-1:0] pc, ir, mdr, a_reg, b_reg, alu_out;
    logic [DATA_W-1:0] rf [0:31];
    logic [DATA_W-1:0] src_a, src_b, imm_ext, alu_result;
    logic [DATA_W-1:0] rd_a, rd_b, wr_data;
    logic [4:0]        wr_reg;
    logic              pc_en;

    assign rd_a    = (ir[25:21] == 5'd0) ? '0 : rf[ir[25:21]];
    assign rd_b    = (ir[20:16] == 5'd0) ? '0 : rf[ir[20:16]];
    assign wr_reg  = bus.RegDst ? ir[15:11] : ir[20:16];
    assign wr_data = bus.MemtoReg ? mdr : alu_out;

    // ori is the only user of a zero-extended immediate
    always_comb begin
        imm_ext = (bus.ALUControl == 3'b010) ? {16'h0000, ir[15:0]} : {{16{ir[15]}}, ir[15:0]};
        src_a   = bus.ALUSrcA ? a_reg : pc;
        case (bus.ALUSrcB)
            2'b00:   src_b = b_reg;
            2'b01:   src_b = DATA_W'(4);
            2'b10:   src_b = imm_ext;
            default: src_b = {imm_ext[DATA_W-3:0], 2'b00};
        endcase
        case (bus.ALUControl)
            3'b000:  alu_result = src_a + src_b;
            3'b001:  alu_result = src_b << ir[10:6];
            3'b010:  alu_result = src_a | src_b;
            3'b100:  alu_result = src_a - src_b;
            3'b101:  alu_result = {src_b[15:0], 16'h0000};
            default: alu_result = '0;
        endcase
    end

    assign bus.zero = (alu_result == '0);
    assign pc_en    = bus.PCWrite | (bus.Branch & bus.zero);

    assign bus.mem_addr  = bus.IorD ? alu_out : pc;
    assign bus.mem_wdata = b_reg;
    assign bus.mem_we    = bus.MemWrite;
    assign bus.Op        = ir[31:26];
    assign bus.Funct     = ir[5:0];
    assign bus.dbg_pc    = pc;

    // All state shares one edge, so a write-back in a fetch cycle still sees the old IR fields
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            ir      <= '0;
            mdr     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            for (int i = 0; i < 32; i++) begin
                rf[i] <= '0;
            end
        end else begin
            if (bus.IRWrite) begin
                ir <= bus.mem_rdata;
            end
            mdr     <= bus.mem_rdata;
            a_reg   <= rd_a;
            b_reg   <= rd_b;
            alu_out <= alu_result;
            if (pc_en) begin
                pc <= bus.PCSrc ? alu_out : alu_result;
            end
            if (bus.RegWrite && (wr_reg != 5'd0)) begin
                rf[wr_reg] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_mips_multicycle_datapath.sv
// tb/tb_mips_multicycle_datapath.sv - directed bench with an instruction-level architectural model
module tb_mips_multicycle_datapath;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_datapath_if bus();

    mips_multicycle_datapath #(.DATA_W(32), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] imem [0:63];
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_word = 32'h0;
    assign bus.mem_rdata = ovr_en ? ovr_word : imem[bus.mem_addr[7:2]];

    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic [31:0] m_rf [0:31];
    logic        check_en = 1'b0;
    logic        last_zero;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC;
        m_ir = 32'h0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
    endtask

    // Architectural meaning of each instruction used in the program
    function automatic logic [31:0] model_result(input logic [31:0] w);
        logic [31:0] rs_v, rt_v;
        rs_v = m_rf[w[25:21]];
        rt_v = m_rf[w[20:16]];
        case (w[31:26])
            6'h08:   return rs_v + {{16{w[15]}}, w[15:0]};
            6'h0F:   return {w[15:0], 16'h0000};
            6'h0D:   return rs_v | {16'h0000, w[15:0]};
            6'h00:   return (w[5:0] == 6'h22) ? rs_v - rt_v : rt_v << w[10:6];
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [2:0] ctl_for(input logic [31:0] w);
        case (w[31:26])
            6'h0F:   return 3'b101;
            6'h0D:   return 3'b010;
            6'h00:   return (w[5:0] == 6'h22) ? 3'b100 : 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic set_idle();
        bus.IorD = 0; bus.MemWrite = 0; bus.IRWrite = 0; bus.PCWrite = 0;
        bus.Branch = 0; bus.PCSrc = 0; bus.ALUSrcA = 0; bus.ALUSrcB = 2'b00;
        bus.ALUControl = 3'b000; bus.RegWrite = 0; bus.RegDst = 0; bus.MemtoReg = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch();
        set_idle();
        bus.IRWrite = 1; bus.PCWrite = 1; bus.ALUSrcB = 2'b01;
        tick();
        m_ir = imem[m_pc[7:2]];
        m_pc = m_pc + 32'd4;
        set_idle();
    endtask

    task automatic run_instr();
        logic [31:0] res;
        logic [4:0]  dst;
        logic        is_r;
        fetch();
        tick();
        is_r = (m_ir[31:26] == 6'h00);
        res  = model_result(m_ir);
        dst  = is_r ? m_ir[15:11] : m_ir[20:16];
        bus.ALUSrcA = 1; bus.ALUSrcB = is_r ? 2'b00 : 2'b10; bus.ALUControl = ctl_for(m_ir);
        #1;
        last_zero = bus.zero;
        chk("exec_zero", {31'b0, bus.zero}, {31'b0, res == 32'h0});
        tick();
        set_idle();
        bus.RegWrite = 1; bus.RegDst = is_r;
        tick();
        if (dst != 5'd0) m_rf[dst] = res;
        set_idle();
    endtask

    // Reads a register out through B -> mem_wdata by loading a "sw $r,0($0)" into IR
    task automatic readout(input int r, input logic [31:0] exp);
        ovr_word = 32'hAC00_0000 | (32'(r) << 16);
        ovr_en = 1;
        set_idle();
        bus.IRWrite = 1;
        tick();
        m_ir = ovr_word;
        ovr_en = 0;
        set_idle();
        tick();
        chk($sformatf("rf%0d", r), bus.mem_wdata, m_rf[r]);
        chk($sformatf("model_rf%0d", r), m_rf[r], exp);
    endtask

    always @(negedge clk) begin
        if (check_en && reset) begin
            chk("dbg_pc", bus.dbg_pc, m_pc);
            chk("op", {26'b0, bus.Op}, {26'b0, m_ir[31:26]});
            chk("funct", {26'b0, bus.Funct}, {26'b0, m_ir[5:0]});
            if (!bus.IorD) chk("mem_addr", bus.mem_addr, m_pc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        imem[0]  = 32'h2008_0005;  // addi $t0,$0,5
        imem[1]  = 32'h3C09_1234;  // lui  $t1,0x1234
        imem[2]  = 32'h3529_8765;  // ori  $t1,$t1,0x8765
        imem[3]  = 32'h2008_0001;  // addi $t0,$0,1
        imem[4]  = 32'h0008_5022;  // sub  $t2,$0,$t0
        imem[5]  = 32'h0108_5022;  // sub  $t2,$t0,$t0
        imem[6]  = 32'h3C08_8000;  // lui  $t0,0x8000
        imem[7]  = 32'h3508_0001;  // ori  $t0,$t0,1
        imem[8]  = 32'h0008_5900;  // sll  $t3,$t0,4
        imem[9]  = 32'h0008_0100;  // sll  $0,$t0,4
        imem[10] = 32'h200C_FFFC;  // addi $t4,$0,-4
        imem[11] = 32'h0180_0008;  // jr   $t4
        imem[63] = 32'h200D_0007;  // addi $t5,$0,7

        set_idle();
        model_reset();
        repeat (2) @(posedge clk);
        #4 reset = 1;
        check_en = 1;
        #1;
        chk("rst_pc", bus.dbg_pc, 32'h0040_0000);
        chk("rst_op", {26'b0, bus.Op}, 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0040_0000);
        chk("rst_wdata", bus.mem_wdata, 32'h0);
        @(posedge clk); #1;

        run_instr();
        chk("addi_pc", bus.dbg_pc, 32'h0040_0004);
        readout(8, 32'h0000_0005);

        run_instr();
        readout(9, 32'h1234_0000);
        run_instr();
        readout(9, 32'h1234_8765);

        run_instr();
        run_instr();
        chk("sub_zero0", {31'b0, last_zero}, 32'h0);
        readout(10, 32'hFFFF_FFFF);
        run_instr();
        chk("sub_zero1", {31'b0, last_zero}, 32'h1);
        readout(10, 32'h0);

        run_instr();
        run_instr();
        readout(8, 32'h8000_0001);
        run_instr();
        readout(11, 32'h0000_0010);
        run_instr();
        readout(0, 32'h0);

        run_instr();
        fetch();
        tick();
        bus.ALUSrcA = 1; bus.ALUSrcB = 2'b00; bus.PCWrite = 1;
        tick();
        m_pc = m_rf[m_ir[25:21]];
        set_idle();
        chk("jr_pc", bus.dbg_pc, 32'hFFFF_FFFC);

        fetch();
        chk("wrap_pc", bus.dbg_pc, 32'h0000_0000);
        tick();
        bus.Branch = 1; bus.ALUSrcA = 1; bus.ALUSrcB = 2'b01;
        #1;
        chk("br_zero0", {31'b0, bus.zero}, 32'h0);
        tick();
        chk("br_not_taken", bus.dbg_pc, 32'h0000_0000);
        set_idle();
        bus.Branch = 1; bus.PCWrite = 1; bus.PCSrc = 1; bus.ALUControl = 3'b011;
        #1;
        chk("ctl011_zero", {31'b0, bus.zero}, 32'h1);
        tick();
        m_pc = 32'h0000_0004;
        set_idle();
        chk("br_taken", bus.dbg_pc, 32'h0000_0004);

        fetch();
        tick();
        bus.ALUSrcA = 1; bus.ALUSrcB = 2'b10; bus.ALUControl = 3'b101;
        tick();
        set_idle();
        bus.RegWrite = 1;
        #2;
        check_en = 0;
        reset = 0;
        model_reset();
        tick();
        #3 reset = 1;
        set_idle();
        check_en = 1;
        #1;
        chk("mid_rst_pc", bus.dbg_pc, 32'h0040_0000);
        chk("mid_rst_funct", {26'b0, bus.Funct}, 32'h0);
        chk("mid_rst_addr", bus.mem_addr, 32'h0040_0000);
        for (int r = 0; r < 32; r++) readout(r, 32'h0);

        check_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
